// File: rtl/ppu_op_sequencer.sv
// ppu_op_sequencer: drives a combinational posit core as a multicycle path.
// Requests are accepted over a valid/ready stream, and the operands are held
// steady on core_* for SETTLE_CYCLES edges. The core result is then captured,
// together with the request tag, into a small in-order result FIFO that is
// drained over a second valid/ready stream.
module ppu_op_sequencer #(
   parameter int N             = 16,
   parameter int OP_SIZE       = 3,
   parameter int SETTLE_CYCLES = 2,
   parameter int FIFO_DEPTH    = 4,
   parameter int TAG_W         = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_p1,
   input  logic [N-1:0]       in_p2,
   input  logic [OP_SIZE-1:0] in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic [N-1:0]       core_p1,
   output logic [N-1:0]       core_p2,
   output logic [OP_SIZE-1:0] core_op,
   input  logic [N-1:0]       core_pout,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_pout,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy,
   output logic [15:0]        done_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t state, state_nxt;

   logic [SET_W-1:0] settle_cnt;
   logic [TAG_W-1:0] tag_q;

   logic [N-1:0]     pout_mem [FIFO_DEPTH];
   logic [TAG_W-1:0] tag_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

   logic accept;
   logic capture;
   logic push;
   logic pop;

   // Saturating increment used by the completion counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
   assign in_ready  = rst_n && (state == IDLE) && (fifo_count < DEPTH_C);
   assign accept    = in_valid && in_ready;
   assign capture   = (state == EXEC) && (settle_cnt == '0);
   assign push      = capture;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign out_pout  = pout_mem[rd_ptr];
   assign out_tag   = tag_mem[rd_ptr];
   assign busy      = (state == EXEC) || (fifo_count != '0);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: one operation in flight, back to IDLE on the capture edge.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    if (settle_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Settle counter: loaded on accept, counts down to the capture edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (accept) begin
         settle_cnt <= SETTLE_LAST;
      end else if ((state == EXEC) && (settle_cnt != '0)) begin
         settle_cnt <= settle_cnt - SET_W'(1);
      end
   end

   // Core operand registers: loaded only on accept, so they never toggle while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_p1 <= '0;
         core_p2 <= '0;
         core_op <= '0;
      end else if (accept) begin
         core_p1 <= in_p1;
         core_p2 <= in_p2;
         core_op <= in_op;
      end
   end

   // Tag of the operation in flight; it is data only and needs no reset.
   always_ff @(posedge clk) begin
      if (accept) tag_q <= in_tag;
   end

   // Result storage: written at the capture edge; the head is read straight out.
   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         pout_mem[wr_ptr] <= core_pout;
         tag_mem[wr_ptr]  <= tag_q;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Completion counter: one per popped result, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n)   done_count <= '0;
      else if (pop) done_count <= sat_inc16(done_count);
   end

endmodule

// File: tb/tb_ppu_op_sequencer.sv
// Bench for ppu_op_sequencer. A stand-in core produces a deterministic function
// of its operands. It reports 0xDEAD until its inputs have been stable across
// one edge, which makes an early capture visible. A negedge monitor keeps a
// scoreboard of expected results and checks that operands are held.
`timescale 1ns/1ps
module tb_ppu_op_sequencer;

   localparam int N      = 16;
   localparam int OPW    = 3;
   localparam int SETTLE = 2;
   localparam int DEPTH  = 4;
   localparam int TAG_W  = 4;
   localparam logic [OPW-1:0] OP_ADD = 3'd0;
   localparam logic [OPW-1:0] OP_MUL = 3'd2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     in_p1 = '0;
   logic [N-1:0]     in_p2 = '0;
   logic [OPW-1:0]   in_op = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic [N-1:0]     core_p1;
   logic [N-1:0]     core_p2;
   logic [OPW-1:0]   core_op;
   logic [N-1:0]     core_pout;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [N-1:0]     out_pout;
   logic [TAG_W-1:0] out_tag;
   logic             busy;
   logic [15:0]      done_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [N-1:0]     pout;
   } res_t;

   res_t           sb[$];
   res_t           exp_r;
   logic [N-1:0]   held_p1 = '0;
   logic [N-1:0]   held_p2 = '0;
   logic [OPW-1:0] held_op = '0;
   int             exp_done = 0;
   logic           sending;

   ppu_op_sequencer #(
      .N(N), .OP_SIZE(OPW), .SETTLE_CYCLES(SETTLE), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_p1(in_p1), .in_p2(in_p2), .in_op(in_op), .in_tag(in_tag),
      .core_p1(core_p1), .core_p2(core_p2), .core_op(core_op), .core_pout(core_pout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pout(out_pout), .out_tag(out_tag),
      .busy(busy), .done_count(done_count)
   );

   always #5 clk = ~clk;

   // Stand-in core. 1.0 + 1.0 gives 2.0 (0x5000) in P16E1; other inputs give a hash.
   function automatic logic [N-1:0] core_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [OPW-1:0] op);
      if (op == OP_ADD && a == 16'h4000 && b == 16'h4000) return 16'h5000;
      return (a ^ {b[7:0], b[15:8]}) + {op, 13'd0} + 16'h1357;
   endfunction

   logic [N-1:0]   last_p1;
   logic [N-1:0]   last_p2;
   logic [OPW-1:0] last_op;
   always @(posedge clk) begin
      last_p1 <= core_p1;
      last_p2 <= core_p2;
      last_op <= core_op;
   end
   assign core_pout = (core_p1 === last_p1 && core_p2 === last_p2 && core_op === last_op)
                      ? core_f(core_p1, core_p2, core_op) : 16'hDEAD;

   // Monitor: operand hold, completion count, head-of-queue contents and ordering.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         held_p1 = '0;
         held_p2 = '0;
         held_op = '0;
         exp_done = 0;
      end else begin
         checks++;
         if (core_p1 !== held_p1 || core_p2 !== held_p2 || core_op !== held_op) begin
            errors++;
            $display("FAIL core_hold: got %h/%h/%h expected %h/%h/%h",
                     core_p1, core_p2, core_op, held_p1, held_p2, held_op);
         end
         checks++;
         if (done_count !== 16'(exp_done)) begin
            errors++;
            $display("FAIL done_count_track: got %0d expected %0d", done_count, exp_done);
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL spurious_result: got tag %h pout %h expected no result",
                        out_tag, out_pout);
            end else begin
               exp_r = sb[0];
               if (out_tag !== exp_r.tag || out_pout !== exp_r.pout) begin
                  errors++;
                  $display("FAIL head: got tag %h pout %h expected tag %h pout %h",
                           out_tag, out_pout, exp_r.tag, exp_r.pout);
               end
               if (out_ready === 1'b1) begin
                  void'(sb.pop_front());
                  exp_done++;
               end
            end
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            sb.push_back({in_tag, core_f(in_p1, in_p2, in_op)});
            held_p1 = in_p1;
            held_p2 = in_p2;
            held_op = in_op;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [N-1:0] p1, input logic [N-1:0] p2,
                       input logic [OPW-1:0] op, input logic [TAG_W-1:0] tag);
      int waited = 0;
      @(posedge clk);
      #1;
      in_p1 = p1;
      in_p2 = p2;
      in_op = op;
      in_tag = tag;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         waited++;
         if (waited > 60) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready %b expected 1 within 60 cycles", in_ready);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 || out_valid === 1'b1) begin
         @(negedge clk);
         waited++;
         if (waited > 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_p1 = 16'h1234;
      in_p2 = 16'h4321;
      in_tag = 4'hA;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
         end
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got out_valid %b busy %b done %0d expected 0 0 0",
                  out_valid, busy, done_count);
      end
      checks++;
      if (core_p1 !== '0 || core_p2 !== '0 || core_op !== '0) begin
         errors++;
         $display("FAIL reset_core: got %h/%h/%h expected 0/0/0", core_p1, core_p2, core_op);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_single_add();
      out_ready = 1'b1;
      send(16'h4000, 16'h4000, OP_ADD, 4'd5);
      @(negedge clk);
      checks++;
      if (core_p1 !== 16'h4000 || core_p2 !== 16'h4000 || core_op !== OP_ADD) begin
         errors++;
         $display("FAIL add_operands: got %h/%h/%h expected 4000/4000/%h",
                  core_p1, core_p2, core_op, OP_ADD);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_exec_flags: got busy %b in_ready %b out_valid %b expected 1 0 0",
                  busy, in_ready, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_early_valid: got %b expected 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pout !== 16'h5000 || out_tag !== 4'd5) begin
         errors++;
         $display("FAIL add_result: got valid %b pout %h tag %h expected 1 5000 5",
                  out_valid, out_pout, out_tag);
      end
      @(negedge clk);
      checks++;
      if (done_count !== 16'd1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_after_pop: got done %0d valid %b busy %b expected 1 0 0",
                  done_count, out_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int t = 0; t < 4; t++)
         send(16'h3000 + 16'(t), 16'h4800 - 16'(t), OP_MUL, 4'(t));
      in_p1 = 16'h2222;
      in_p2 = 16'h5555;
      in_op = OP_MUL;
      in_tag = 4'd4;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_in_ready: got %b expected 0 (cycle %0d)", in_ready, i);
         end
      end
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 4'd0) begin
         errors++;
         $display("FAIL bp_head: got valid %b tag %h expected 1 0", out_valid, out_tag);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_tag !== 4'd1) begin
         errors++;
         $display("FAIL bp_after_pop: got in_ready %b tag %h expected 1 1", in_ready, out_tag);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
      checks++;
      if (done_count !== 16'd6) begin
         errors++;
         $display("FAIL bp_done_count: got %0d expected 6", done_count);
      end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, OP_ADD, 4'd6);
      send(16'h3333, 16'h4444, OP_MUL, 4'd7);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_tag !== 4'd7) begin
            errors++;
            $display("FAIL simul_head: got valid %b tag %h expected 1 7", out_valid, out_tag);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_count: got valid %b expected 0 after one pop", out_valid);
      end
   endtask

   task automatic test_reset_mid_exec();
      out_ready = 1'b0;
      send(16'h0101, 16'h0202, OP_ADD, 4'd8);
      send(16'h0303, 16'h0404, OP_ADD, 4'd9);
      send(16'h0505, 16'h0606, OP_MUL, 4'd10);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done_count !== 16'd0) begin
         errors++;
         $display("FAIL midrst_state: got valid %b busy %b done %0d expected 0 0 0",
                  out_valid, busy, done_count);
      end
      checks++;
      if (core_p1 !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_core: got p1 %h in_ready %b expected 0 1", core_p1, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ghost: got valid %b tag %h expected no result", out_valid, out_tag);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_random_order();
      sending = 1'b1;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send(16'($urandom()), 16'($urandom()), 3'($urandom_range(0, 7)), 4'(i));
            sending = 1'b0;
         end
         begin
            while (sending) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      drain();
      @(negedge clk);
      checks++;
      if (done_count !== 16'd20) begin
         errors++;
         $display("FAIL random_done_count: got %0d expected 20", done_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_backpressure();
      test_simultaneous();
      test_reset_mid_exec();
      test_random_order();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
